// File: rtl/mole_pkg.sv
// Shared types and lifetime table for the multi-hole mole timer.
package mole_pkg;

  localparam logic [1:0] DIFF_EASY   = 2'd0;
  localparam logic [1:0] DIFF_MEDIUM = 2'd1;
  localparam logic [1:0] DIFF_HARD   = 2'd2;
  localparam logic [1:0] DIFF_EXPERT = 2'd3;

  localparam logic [9:0] BASE_EASY   = 10'd260;
  localparam logic [9:0] BASE_MEDIUM = 10'd180;
  localparam logic [9:0] BASE_HARD   = 10'd80;
  localparam logic [9:0] BASE_EXPERT = 10'd50;
  localparam logic [9:0] STEP_EASY   = 10'd20;
  localparam logic [9:0] STEP_MEDIUM = 10'd10;
  localparam logic [9:0] STEP_HARD   = 10'd10;
  localparam logic [9:0] STEP_EXPERT = 10'd5;

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} hole_state_e;

  // Lifetime in 10 ms units: base + step * moletime (max 400).
  function automatic logic [9:0] life_units(input logic [1:0] diff, input logic [2:0] t);
    logic [9:0] base;
    logic [9:0] step;
    case (diff)
      DIFF_EASY:   begin base = BASE_EASY;   step = STEP_EASY;   end
      DIFF_MEDIUM: begin base = BASE_MEDIUM; step = STEP_MEDIUM; end
      DIFF_HARD:   begin base = BASE_HARD;   step = STEP_HARD;   end
      default:     begin base = BASE_EXPERT; step = STEP_EXPERT; end
    endcase
    return base + step * {7'd0, t};
  endfunction

endpackage

// File: rtl/mole_channel.sv
// One hole: DOWN/UP state, lifetime countdown, whack edge detect, hit/miss pulses.
module mole_channel
  import mole_pkg::*;
#(
  parameter int LIFE_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              freeze_i,
  input  logic              tick_i,
  input  logic              spawn_i,
  input  logic [LIFE_W-1:0] life_i,
  input  logic              whack_i,
  output logic              up_o,
  output logic              hit_o,
  output logic              miss_o
);

  hole_state_e       state_q, state_d;
  logic [LIFE_W-1:0] cnt_q, cnt_d;
  logic              whack_q, hit_q, hit_d, miss_q, miss_d, rise;

  // A line already high when the mole rises must be released before it can hit.
  assign rise = whack_i & ~whack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (!enable_i) begin
      state_d = DOWN;
      cnt_d   = '0;
    end else if (!freeze_i) begin
      case (state_q)
        DOWN: if (spawn_i) begin
          state_d = UP;
          cnt_d   = life_i;
        end
        UP: begin
          if (rise) begin
            state_d = DOWN;
            cnt_d   = '0;
            hit_d   = 1'b1;
          end else if (tick_i) begin
            if (cnt_q <= LIFE_W'(1)) begin
              state_d = DOWN;
              cnt_d   = '0;
              miss_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = DOWN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= DOWN;
      cnt_q   <= '0;
      whack_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      whack_q <= whack_i;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign up_o   = (state_q == UP);
  assign hit_o  = hit_q;
  assign miss_o = miss_q;

endmodule

// File: rtl/mole_timer_array.sv
// Multi-hole mole timer: prescaler, spawn decode, per-hole channels, saturating tallies.
// Define PAUSE_EN to add a pause input that freezes all timing and ignores inputs.
module mole_timer_array
  import mole_pkg::*;
#(
  parameter  int NUM_MOLES    = 9,
  parameter  int CLK_PER_10MS = 1000000,
  parameter  int SCORE_W      = 8,
  parameter  int LIFE_W       = 10,
  localparam int IDX_W        = $clog2(NUM_MOLES)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           difficulty,
  input  logic                 spawn,
  input  logic [IDX_W-1:0]     spawn_idx,
  input  logic [2:0]           moletime,
  input  logic [NUM_MOLES-1:0] whack,
`ifdef PAUSE_EN
  input  logic                 pause,
`endif
  output logic [NUM_MOLES-1:0] mole_up,
  output logic [NUM_MOLES-1:0] hit_mask,
  output logic [NUM_MOLES-1:0] miss_mask,
  output logic                 spawn_err,
  output logic [SCORE_W-1:0]   hit_count,
  output logic [SCORE_W-1:0]   miss_count
);

  localparam int              PRE_W   = (CLK_PER_10MS > 1) ? $clog2(CLK_PER_10MS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_10MS - 1);
  localparam logic [IDX_W:0]  NM      = (IDX_W + 1)'(NUM_MOLES);

  logic                    pause_w, run, tick, spawn_go, idx_ok;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic                    spawn_err_q, spawn_err_d;
  logic [SCORE_W-1:0]      hit_cnt_q, miss_cnt_q;
  logic [NUM_MOLES-1:0]    up, hit, miss, spawn_vec;
  logic [2**IDX_W-1:0]     up_ext;
  logic [LIFE_W-1:0]       life;

`ifdef PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  function automatic logic [4:0] popcnt(input logic [NUM_MOLES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < NUM_MOLES; k++) c = c + {4'd0, v[k]};
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [4:0] b);
    logic [SCORE_W+4:0] s;
    s = {5'd0, a} + {{SCORE_W{1'b0}}, b};
    return (s > {5'd0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  assign run  = enable & ~pause_w;
  assign tick = run & (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    if (!enable)  pre_d = '0;
    else if (run) pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
  end

  // Out-of-range indices read as "not up" through the zero-extended view.
  assign up_ext      = (2**IDX_W)'(up);
  assign spawn_go    = spawn & run;
  assign idx_ok      = {1'b0, spawn_idx} < NM;
  assign spawn_err_d = spawn_go & (~idx_ok | up_ext[spawn_idx]);
  assign life        = LIFE_W'(life_units(difficulty, moletime));

  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_ch
    assign spawn_vec[i] = spawn_go & (spawn_idx == IDX_W'(i));
    mole_channel #(.LIFE_W(LIFE_W)) u_ch (
      .clk_i    (CLK100MHZ),
      .rst_n_i  (rst_n),
      .enable_i (enable),
      .freeze_i (pause_w),
      .tick_i   (tick),
      .spawn_i  (spawn_vec[i]),
      .life_i   (life),
      .whack_i  (whack[i]),
      .up_o     (up[i]),
      .hit_o    (hit[i]),
      .miss_o   (miss[i])
    );
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      spawn_err_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      pre_q       <= pre_d;
      spawn_err_q <= spawn_err_d;
      hit_cnt_q   <= sat_add(hit_cnt_q, popcnt(hit));
      miss_cnt_q  <= sat_add(miss_cnt_q, popcnt(miss));
    end
  end

  assign mole_up    = up;
  assign hit_mask   = hit;
  assign miss_mask  = miss;
  assign spawn_err  = spawn_err_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_mole_timer_array.sv
// Directed bench for mole_timer_array: lifetime table vectors plus multi-cycle corner sequences.
module tb_mole_timer_array;

  localparam int NM  = 9;
  localparam int CPT = 4;
  localparam int SW  = 8;
  localparam int LW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    difficulty = '0;
  logic          spawn = 1'b0;
  logic [3:0]    spawn_idx = '0;
  logic [2:0]    moletime = '0;
  logic [NM-1:0] whack = '0;
`ifdef PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic [NM-1:0] mole_up, hit_mask, miss_mask;
  logic          spawn_err;
  logic [SW-1:0] hit_count, miss_count;

  int checks = 0;
  int failures = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  mole_timer_array #(.NUM_MOLES(NM), .CLK_PER_10MS(CPT), .SCORE_W(SW), .LIFE_W(LW)) dut (
    .CLK100MHZ  (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .difficulty (difficulty),
    .spawn      (spawn),
    .spawn_idx  (spawn_idx),
    .moletime   (moletime),
    .whack      (whack),
`ifdef PAUSE_EN
    .pause      (pause),
`endif
    .mole_up    (mole_up),
    .hit_mask   (hit_mask),
    .miss_mask  (miss_mask),
    .spawn_err  (spawn_err),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct {
    int hole;
    int diff;
    int t;
    int life;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input int h, input int d, input int t);
    spawn = 1'b1;
    spawn_idx = 4'(h);
    difficulty = 2'(d);
    moletime = 3'(t);
    step();
    spawn = 1'b0;
  endtask

  // n = edges after the spawn edge until miss_mask[h] is seen (budget on timeout).
  task automatic wait_miss(input int h, input int budget, output int n, output logic up_ok);
    n = 0;
    up_ok = 1'b1;
    while (n < budget) begin
      step();
      n++;
      if (miss_mask[h]) break;
      if (!mole_up[h]) up_ok = 1'b0;
    end
  endtask

  task automatic quiet(input int cyc, output int events);
    events = 0;
    repeat (cyc) begin
      step();
      if (hit_mask != '0 || miss_mask != '0 || spawn_err || mole_up != '0) events++;
    end
  endtask

  initial begin
    int   n, n0, ev;
    logic ok;

    tbl[0] = '{3, 2, 0, 80};
    tbl[1] = '{6, 3, 0, 50};
    tbl[2] = '{7, 3, 7, 85};
    tbl[3] = '{8, 1, 2, 200};
    tbl[4] = '{1, 2, 5, 130};
    tbl[5] = '{0, 0, 0, 260};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mole_up", 32'(mole_up), 0);
    chk("rst_hit_mask", 32'(hit_mask), 0);
    chk("rst_miss_mask", 32'(miss_mask), 0);
    chk("rst_spawn_err", 32'(spawn_err), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    // whack on a DOWN hole does nothing
    whack[8] = 1'b1;
    step();
    step();
    chk("whack_down_hit", 32'(hit_mask), 0);
    whack[8] = 1'b0;
    step();

    // spawn while disabled is silently dropped
    enable = 1'b0;
    do_spawn(8, 0, 0);
    step();
    chk("spawn_disabled_up", 32'(mole_up), 0);
    chk("spawn_disabled_err", 32'(spawn_err), 0);
    enable = 1'b1;
    step();

    // Lifetime table: expiry on the L-th tick after spawn
    for (int v = 0; v < 6; v++) begin
      do_spawn(tbl[v].hole, tbl[v].diff, tbl[v].t);
      chk("tbl_up", 32'(mole_up), 32'(1) << tbl[v].hole);
      wait_miss(tbl[v].hole, 4 * tbl[v].life + 20, n, ok);
      chk_range("tbl_life_cycles", n, 4 * tbl[v].life - 3, 4 * tbl[v].life);
      chk("tbl_miss_mask", 32'(miss_mask), 32'(1) << tbl[v].hole);
      chk("tbl_up_held", 32'(ok), 1);
      chk("tbl_up_dropped", 32'(mole_up), 0);
      exp_miss++;
      step();
      chk("tbl_miss_count", 32'(miss_count), 32'(exp_miss));
      chk("tbl_miss_clear", 32'(miss_mask), 0);
    end

    // Hit on hole 0 (L=400) 100 cycles in; no miss later
    do_spawn(0, 0, 7);
    repeat (99) step();
    whack[0] = 1'b1;
    step();
    chk("hit0_mask", 32'(hit_mask), 32'h1);
    chk("hit0_up", 32'(mole_up), 0);
    chk("hit0_nomiss", 32'(miss_mask), 0);
    exp_hit++;
    step();
    chk("hit0_count", 32'(hit_count), 32'(exp_hit));
    chk("hit0_clear", 32'(hit_mask), 0);
    whack[0] = 1'b0;
    quiet(1650, ev);
    chk("hit0_no_late_event", 32'(ev), 0);

    // Double spawn on hole 5: error pulse, original L=50 countdown kept
    do_spawn(5, 3, 0);
    chk("dbl_first_err", 32'(spawn_err), 0);
    repeat (9) step();
    do_spawn(5, 0, 7);
    chk("dbl_err", 32'(spawn_err), 1);
    step();
    chk("dbl_err_clear", 32'(spawn_err), 0);
    wait_miss(5, 250, n0, ok);
    chk_range("dbl_life_cycles", n0 + 11, 197, 200);
    chk("dbl_miss_mask", 32'(miss_mask), 32'h020);
    exp_miss++;

    // A tick just landed; holes 1,2 spawned off-tick expire together, whack[2] in that cycle
    do_spawn(1, 3, 0);
    do_spawn(2, 3, 0);
    repeat (197) step();
    chk("pair_up", 32'(mole_up), 32'h006);
    whack[2] = 1'b1;
    step();
    chk("pair_hit_mask", 32'(hit_mask), 32'h004);
    chk("pair_miss_mask", 32'(miss_mask), 32'h002);
    exp_hit++;
    exp_miss++;
    step();
    chk("pair_hit_count", 32'(hit_count), 32'(exp_hit));
    chk("pair_miss_count", 32'(miss_count), 32'(exp_miss));
    whack[2] = 1'b0;

    // Out-of-range index
    do_spawn(12, 0, 0);
    chk("idx12_err", 32'(spawn_err), 1);
    chk("idx12_up", 32'(mole_up), 0);
    step();

    // whack held through spawn: only a fresh press hits
    whack[7] = 1'b1;
    step();
    do_spawn(7, 0, 0);
    ev = 0;
    repeat (3) begin
      step();
      if (hit_mask[7]) ev++;
    end
    chk("held_no_hit", 32'(ev), 0);
    chk("held_up", 32'(mole_up[7]), 1);
    whack[7] = 1'b0;
    step();
    whack[7] = 1'b1;
    step();
    chk("held_repress_hit", 32'(hit_mask), 32'h080);
    exp_hit++;
    whack[7] = 1'b0;
    step();
    chk("held_hit_count", 32'(hit_count), 32'(exp_hit));

    // Reset mid-count
    do_spawn(4, 3, 0);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_up", 32'(mole_up), 0);
    chk("midrst_hit_count", 32'(hit_count), 0);
    chk("midrst_miss_count", 32'(miss_count), 0);
    exp_hit = 0;
    exp_miss = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet(250, ev);
    chk("midrst_quiet", 32'(ev), 0);

    // enable drop keeps counters, no pulses
    do_spawn(3, 0, 0);
    whack[3] = 1'b1;
    step();
    chk("en_hit_mask", 32'(hit_mask), 32'h008);
    exp_hit++;
    whack[3] = 1'b0;
    do_spawn(4, 3, 0);
    repeat (20) step();
    enable = 1'b0;
    step();
    chk("en_drop_up", 32'(mole_up), 0);
    quiet(250, ev);
    chk("en_drop_quiet", 32'(ev), 0);
    chk("en_drop_hit_count", 32'(hit_count), 32'(exp_hit));
    chk("en_drop_miss_count", 32'(miss_count), 0);
    enable = 1'b1;
    step();

    // 300 hits saturate the 8-bit tally
    for (int k = 0; k < 300; k++) begin
      do_spawn(k % NM, 0, 0);
      whack[k % NM] = 1'b1;
      step();
      whack[k % NM] = 1'b0;
      step();
      if (k == 99) chk("sat_mid_count", 32'(hit_count), 32'(exp_hit + 100));
    end
    repeat (2) step();
    chk("sat_hit_count", 32'(hit_count), 255);
    chk("sat_up", 32'(mole_up), 0);

`ifdef PAUSE_EN
    // 200-cycle pause (50 ticks) shifts expiry by exactly that much
    do_spawn(6, 3, 0);
    repeat (79) step();
    pause = 1'b1;
    repeat (200) step();
    chk("pause_up_held", 32'(mole_up), 32'h040);
    pause = 1'b0;
    wait_miss(6, 500, n, ok);
    chk_range("pause_life_cycles", n + 279, 397, 400);
    chk("pause_miss_mask", 32'(miss_mask), 32'h040);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
